bus_sequencer: RTL and testbench
================================

// Module: bus_sequencer
// PURPOSE
//  6502 bus-cycle sequencer for the bifröst CPLD.
//  - Divides the 8 MHz board clock into the 1 MHz phi2 clock.
//  - Holds the 6502 in reset for a fixed number of phi2 cycles.
//  - Decodes the CPU address into active-low chip selects that are asserted only while phi2 is high.
//  - Stretches accesses to the slow SID region with RDY wait states.
//  - Sits between the 6502 address bus and the RAM/VIA/UART/SID chip-select pins.
// PARAMETERS
//  DIVIDE_LOG2   3      phase counter width; phi2 = clock / 2**DIVIDE_LOG2 (8 MHz -> 1 MHz)
//  RESET_CYCLES  8      full phi2 cycles reset6502 is held low after reset deasserts (1..63)
//  SLOW_WAIT     1      extra phi2 cycles of RDY-low per SID access (0 disables, max 7)
//  IO_PAGE       8'hDE  addr[15:8] of the I/O page
// PORTS
//  clock      in   1   8 MHz board clock; all logic on posedge
//  reset      in   1   synchronous, active-high
//  addr       in   16  6502 address bus
//  clockout   out  1   phi2 to 6502
//  reset6502  out  1   6502 RESB, active low
//  busen      out  1   6502 BE; 0 while reset6502 is low, else 1
//  ready      out  1   6502 RDY; 0 = wait state
//  ram_cs     out  1   active low
//  via1_cs    out  1   active low
//  via2_cs    out  1   active low
//  uart_cs    out  1   active low
//  sid_cs     out  1   active low
// BEHAVIOUR
//  Clock and reset
//  - Clock/reset: single clock domain, clock; reset is synchronous and active-high.
//  - Reset values: phase=0, clockout=0, reset6502=0, busen=0, ready=1, all *_cs=1, wait_cnt=0, rst_cnt=0, skip=0.
//  Phase counter and phi2
//  - phase: a DIVIDE_LOG2-bit counter that increments every clock and wraps from 2**N-1 to 0.
//  - clockout = phase MSB (registered), i.e. low for phases 0..H-1 and high for phases H..2**N-1, where H = 2**(N-1).
//  Reset hold
//  - rst_cnt increments at every phase wrap (2**N-1 -> 0) while it is below RESET_CYCLES.
//  - reset6502 and busen go high on the clock edge where rst_cnt reaches RESET_CYCLES; this always lands at phase 0, with phi2 low.
//  Address decode
//  - Decode is sampled on the edge at phase H-1 into a registered one-hot `sel`.
//    - addr[15:8] != IO_PAGE -> RAM
//    - IO_PAGE, addr[7:4] = 0 -> VIA1
//    - IO_PAGE, addr[7:4] = 1 -> VIA2
//    - IO_PAGE, addr[7:4] = 2 -> UART
//    - IO_PAGE, addr[7:4] = 4 or 5 -> SID
//    - any other I/O-page address -> no select
//  - *_cs = ~sel only during phases H..2**N-1 and only while reset6502 = 1; otherwise all *_cs = 1.
//  - Chip selects deassert on the edge into phase 0 and never glitch mid-phase.
//  Wait states
//  - At the phase H-1 sample, if sel = SID, SLOW_WAIT > 0 and skip = 0, then wait_cnt <= SLOW_WAIT.
//  - ready = (wait_cnt == 0), registered; it falls at phase H of the first SID cycle.
//  - wait_cnt decrements on every edge at phase 2**N-1 while nonzero. On the 1 -> 0 step, set skip = 1.
//  - skip suppresses re-trigger at the next phase H-1 sample, because the CPU still holds the same address there; skip clears at that sample.
//  - A SID access therefore spans 1+SLOW_WAIT phi2-high windows, with sid_cs low in each window and high in every phi1 gap.
//  - Non-SID regions never drop ready.
//  Boundary conditions
//  - Reset asserted at any phase, including mid-wait: all state returns to the reset values on the next edge, and ready=1 immediately.
//  - Back-to-back SID accesses: the second access gets its full wait.
//  - An address change between samples has no effect until the next phase H-1 sample.
//  - With SLOW_WAIT=0, ready is constant 1.
// TESTING
//  - Reset for 3 clocks, then release:
//    - clockout toggles every 4 clocks (period 8).
//    - reset6502 and busen rise exactly 64 clocks after release, at phase 0.
//  - Hold addr=16'h1234 after reset6502 is high:
//    - ram_cs low exactly in phases 4..7 of every cycle.
//    - all other selects high; ready stays 1.
//  - Sweep addr over DE05, DE15, DE25, DE35, DE45, DE55, DEF0:
//    - VIA1, VIA2, UART, none, SID, SID, none respectively, each select low only in phases 4..7.
//  - addr=16'hDE40, SLOW_WAIT=1:
//    - ready low from phase 4 of cycle 1 to phase 0 of cycle 2.
//    - sid_cs low in phases 4..7 of both cycles.
//    - no third wait.
//  - Two consecutive SID cycles (DE41 held 2 cycles, then DE42):
//    - the DE42 access gets its own single wait cycle.
//  - Assert reset at phase 5 of a SID wait cycle:
//    - next edge: ready=1, all *_cs=1, reset6502=0, clockout=0.
//    - the full 64-clock reset hold is repeated.

Source files
------------

// File: rtl/bus_sequencer.sv
// 6502 bus-cycle sequencer: phi2 generation, CPU reset hold, address decode
// into phi2-qualified active-low chip selects, and RDY wait states for SID.
module bus_sequencer #(
    parameter int          DIVIDE_LOG2  = 3,
    parameter int          RESET_CYCLES = 8,
    parameter int          SLOW_WAIT    = 1,
    parameter logic [7:0]  IO_PAGE      = 8'hDE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    output logic        clockout,
    output logic        reset6502,
    output logic        busen,
    output logic        ready,
    output logic        ram_cs,
    output logic        via1_cs,
    output logic        via2_cs,
    output logic        uart_cs,
    output logic        sid_cs
);

    localparam int             N          = DIVIDE_LOG2;
    localparam logic [N-1:0]   PH_LAST    = {N{1'b1}};
    localparam logic [N-1:0]   PH_SAMPLE  = PH_LAST >> 1;
    localparam logic [N-1:0]   PH_ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [5:0]     RST_TARGET = 6'(RESET_CYCLES);
    localparam logic [2:0]     WAIT_LOAD  = 3'(SLOW_WAIT);
    localparam logic [4:0]     SEL_SID    = 5'b10000;

    logic [N-1:0] phase_q, phase_d;
    logic [5:0]   rst_cnt_q, rst_cnt_d;
    logic [2:0]   wait_cnt_q, wait_cnt_d;
    logic         skip_q, skip_d;
    logic         released_q, released_d;
    logic         ready_q, ready_d;
    logic [4:0]   sel_q, sel_d;
    logic [4:0]   cs_q, cs_d;
    logic         sample_s, wrap_s, high_s;

    // One-hot select, bit order {sid, uart, via2, via1, ram}.
    function automatic logic [4:0] decode(input logic [15:0] a);
        logic [4:0] s;
        s = 5'b00000;
        if (a[15:8] != IO_PAGE) begin
            s = 5'b00001;
        end else begin
            case (a[7:4])
                4'h0:       s = 5'b00010;
                4'h1:       s = 5'b00100;
                4'h2:       s = 5'b01000;
                4'h4, 4'h5: s = 5'b10000;
                default:    s = 5'b00000;
            endcase
        end
        return s;
    endfunction

    // Next-state logic for phase, reset hold, decode and wait states.
    always_comb begin
        phase_d    = phase_q + PH_ONE;
        sample_s   = (phase_q == PH_SAMPLE);
        wrap_s     = (phase_q == PH_LAST);
        rst_cnt_d  = rst_cnt_q;
        sel_d      = sel_q;
        wait_cnt_d = wait_cnt_q;
        skip_d     = skip_q;

        if (wrap_s && (rst_cnt_q < RST_TARGET)) begin
            rst_cnt_d = rst_cnt_q + 6'd1;
        end else begin
            rst_cnt_d = rst_cnt_q;
        end
        released_d = (rst_cnt_d == RST_TARGET);

        if (sample_s) begin
            sel_d  = decode(addr);
            skip_d = 1'b0;
            // skip covers the CPU still presenting the same SID address after its wait ends
            if ((sel_d == SEL_SID) && (SLOW_WAIT > 0) && !skip_q && (wait_cnt_q == 3'd0)) begin
                wait_cnt_d = WAIT_LOAD;
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else if (wrap_s && (wait_cnt_q != 3'd0)) begin
            wait_cnt_d = wait_cnt_q - 3'd1;
            if (wait_cnt_q == 3'd1) begin
                skip_d = 1'b1;
            end else begin
                skip_d = skip_q;
            end
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        ready_d = (wait_cnt_d == 3'd0);
        high_s  = phase_d[N-1];
        if (high_s && released_d) begin
            cs_d = ~sel_d;
        end else begin
            cs_d = 5'b11111;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q    <= {N{1'b0}};
            rst_cnt_q  <= 6'd0;
            wait_cnt_q <= 3'd0;
            skip_q     <= 1'b0;
            released_q <= 1'b0;
            ready_q    <= 1'b1;
            sel_q      <= 5'b00000;
            cs_q       <= 5'b11111;
        end else begin
            phase_q    <= phase_d;
            rst_cnt_q  <= rst_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            skip_q     <= skip_d;
            released_q <= released_d;
            ready_q    <= ready_d;
            sel_q      <= sel_d;
            cs_q       <= cs_d;
        end
    end

    assign clockout  = phase_q[N-1];
    assign reset6502 = released_q;
    assign busen     = released_q;
    assign ready     = ready_q;
    assign ram_cs    = cs_q[0];
    assign via1_cs   = cs_q[1];
    assign via2_cs   = cs_q[2];
    assign uart_cs   = cs_q[3];
    assign sid_cs    = cs_q[4];

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: expected output vectors are queued as each
// clock is driven and popped for comparison once the edge has settled.
module tb_bus_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] addr;
    logic        clockout, reset6502, busen, ready;
    logic        ram_cs, via1_cs, via2_cs, uart_cs, sid_cs;

    int checks = 0;
    int errors = 0;
    int ph     = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    // Selects in bench order {ram, via1, via2, uart, sid}
    localparam logic [4:0] S_RAM  = 5'b10000;
    localparam logic [4:0] S_VIA1 = 5'b01000;
    localparam logic [4:0] S_VIA2 = 5'b00100;
    localparam logic [4:0] S_UART = 5'b00010;
    localparam logic [4:0] S_SID  = 5'b00001;
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [8:0] V_RESET = {1'b0, 1'b0, 1'b0, 1'b1, 5'b11111};

    bus_sequencer dut (
        .clock(clock), .reset(reset), .addr(addr),
        .clockout(clockout), .reset6502(reset6502), .busen(busen), .ready(ready),
        .ram_cs(ram_cs), .via1_cs(via1_cs), .via2_cs(via2_cs),
        .uart_cs(uart_cs), .sid_cs(sid_cs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {clockout, reset6502, busen, ready, ram, via1, via2, uart, sid}
    function automatic logic [8:0] expv(int p, bit rel, logic [4:0] sel, bit wlow);
        logic       hi;
        logic [4:0] cs;
        hi = (p >= 4);
        cs = (hi && rel) ? ~sel : 5'b11111;
        return {hi, rel, rel, ~(wlow && hi), cs};
    endfunction

    task automatic tick(input logic [8:0] e, input string tag);
        logic [8:0] obs;
        logic [8:0] ex;
        string      t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        ex  = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {clockout, reset6502, busen, ready, ram_cs, via1_cs, via2_cs, uart_cs, sid_cs};
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s phase=%0d: got %b expected %b", t, ph, obs, ex);
        end
    endtask

    task automatic hold_check(input string tag);
        for (int k = 1; k <= 64; k++) begin
            ph = k % 8;
            tick(expv(ph, (k == 64), S_NONE, 1'b0), tag);
        end
    endtask

    task automatic run_cycle(input logic [15:0] a, input logic [4:0] sel, input bit wlow, input string tag);
        addr = a;
        for (int i = 0; i < 8; i++) begin
            ph = (ph + 1) % 8;
            tick(expv(ph, 1'b1, sel, wlow), tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        addr  = 16'h1234;
        for (int i = 0; i < 3; i++) tick(V_RESET, "reset");
        reset = 1'b0;
        hold_check("hold1");

        run_cycle(16'h1234, S_RAM, 1'b0, "ram1");
        run_cycle(16'h1234, S_RAM, 1'b0, "ram2");

        run_cycle(16'hDE05, S_VIA1, 1'b0, "sw_de05");
        run_cycle(16'hDE15, S_VIA2, 1'b0, "sw_de15");
        run_cycle(16'hDE25, S_UART, 1'b0, "sw_de25");
        run_cycle(16'hDE35, S_NONE, 1'b0, "sw_de35");
        run_cycle(16'hDE45, S_SID,  1'b1, "sw_de45");
        run_cycle(16'hDE55, S_SID,  1'b0, "sw_de55_held");
        run_cycle(16'hDEF0, S_NONE, 1'b0, "sw_def0");

        run_cycle(16'hDE40, S_SID, 1'b1, "sid_c1");
        run_cycle(16'hDE40, S_SID, 1'b0, "sid_c2");
        run_cycle(16'h1234, S_RAM, 1'b0, "sid_no3rd");

        run_cycle(16'hDE41, S_SID, 1'b1, "b2b_41a");
        run_cycle(16'hDE41, S_SID, 1'b0, "b2b_41b");
        run_cycle(16'hDE42, S_SID, 1'b1, "b2b_42a");
        run_cycle(16'hDE42, S_SID, 1'b0, "b2b_42b");
        run_cycle(16'h0400, S_RAM, 1'b0, "b2b_ram");

        addr = 16'hDE40;
        for (int i = 0; i < 5; i++) begin
            ph = (ph + 1) % 8;
            tick(expv(ph, 1'b1, S_SID, 1'b1), "midwait");
        end
        reset = 1'b1;
        addr  = 16'h1234;
        tick(V_RESET, "reset_midwait");
        reset = 1'b0;
        hold_check("hold2");
        run_cycle(16'h1234, S_RAM, 1'b0, "ram_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
